// File: rtl/meas_sequencer.sv
// Settle-then-acquire measurement sequencer: sums, averages and peaks NUM_SAMPLES ADC magnitudes.
// Optional ACQUIRE inactivity timeout is compiled in with MEAS_TIMEOUT_EN.
module meas_sequencer #(
    parameter int SAMPLE_W       = 12,
    parameter int NUM_SAMPLES    = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_i,
    output logic                                    busy_o,
    output logic                                    timer_start_o,
    input  logic                                    timer_done_i,
    input  logic                                    sample_valid_i,
    input  logic [SAMPLE_W-1:0]                     sample_i,
    output logic                                    result_valid_o,
    output logic [SAMPLE_W+$clog2(NUM_SAMPLES)-1:0] sum_o,
    output logic [SAMPLE_W-1:0]                     mean_o,
    output logic [SAMPLE_W-1:0]                     peak_o,
    output logic                                    error_o
);

    localparam int CNT_W = $clog2(NUM_SAMPLES);
    localparam int SUM_W = SAMPLE_W + CNT_W;

    if (NUM_SAMPLES < 2 || (NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("meas_sequencer: NUM_SAMPLES must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SETTLE,
        ACQUIRE,
        REPORT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SUM_W-1:0]    acc;
    logic [SAMPLE_W-1:0] peak;
    logic [CNT_W-1:0]    count;

    logic [SAMPLE_W-1:0] mag;
    logic [SUM_W-1:0]    acc_nxt;
    logic [SAMPLE_W-1:0] peak_nxt;
    logic                accept;
    logic                last;
    logic                timeout_hit;

    // Two's-complement negate in SAMPLE_W bits maps the most negative code onto its exact magnitude.
    always_comb begin
        mag      = sample_i[SAMPLE_W-1] ? (~sample_i + 1'b1) : sample_i;
        accept   = (state == ACQUIRE) && sample_valid_i;
        last     = accept && (count == CNT_W'(NUM_SAMPLES - 1));
        acc_nxt  = acc + SUM_W'(mag);
        peak_nxt = (mag > peak) ? mag : peak;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ARM;
            ARM:     state_nxt = SETTLE;
            SETTLE:  if (timer_done_i) state_nxt = ACQUIRE;
            ACQUIRE: begin
                if (last) begin
                    state_nxt = REPORT;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o         <= 1'b0;
            timer_start_o  <= 1'b0;
            result_valid_o <= 1'b0;
            sum_o          <= '0;
            mean_o         <= '0;
            peak_o         <= '0;
        end else begin
            busy_o         <= (state_nxt != IDLE);
            timer_start_o  <= (state_nxt == ARM);
            result_valid_o <= last;
            if (last) begin
                sum_o  <= acc_nxt;
                mean_o <= acc_nxt[SUM_W-1:CNT_W];
                peak_o <= peak_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            peak  <= '0;
            count <= '0;
        end else if (state == IDLE && start_i) begin
            acc   <= '0;
            peak  <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= acc_nxt;
            peak  <= peak_nxt;
            count <= count + 1'b1;
        end
    end

`ifdef MEAS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts idle ACQUIRE cycles since entry or the last accepted sample.
    assign timeout_hit = (state == ACQUIRE) && !sample_valid_i
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            error_o <= 1'b0;
        end else begin
            error_o <= timeout_hit;
            if (state != ACQUIRE || accept) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error_o     = 1'b0;
`endif

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Sequences one beacon-magnitude measurement: on start, fires the microsecond settle timer, waits for its done pulse, then accumulates NUM_SAMPLES ADC samples.
- Reports sum, mean and peak of the sample magnitudes.
- Sits between the ADC sample stream and the direction/distance logic.
- Drives the timer's start_i and consumes its done_o.

Parameters:
- SAMPLE_W, 12: width of the signed two's-complement ADC sample.
- NUM_SAMPLES, 64: samples per measurement. Must be a power of two, at least 2.
- TIMEOUT_CYCLES, 4096: maximum clk cycles allowed between accepted samples. Used only when MEAS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request a measurement. Sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- timer_start_o  out  1  one-cycle start pulse to the settle timer.
- timer_done_i  in  1  one-cycle done pulse from the settle timer.
- sample_valid_i  in  1  sample_i is valid this cycle.
- sample_i  in  SAMPLE_W  signed ADC sample.
- result_valid_o  out  1  one-cycle pulse; result outputs are valid and held until the next result.
- sum_o  out  SAMPLE_W+$clog2(NUM_SAMPLES)  unsigned sum of magnitudes.
- mean_o  out  SAMPLE_W  sum_o >> $clog2(NUM_SAMPLES), truncated.
- peak_o  out  SAMPLE_W  largest magnitude in the measurement.
- error_o  out  1  one-cycle timeout pulse. Tied to 0 when MEAS_TIMEOUT_EN is undefined.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - Accumulator, peak and sample count cleared.
- Magnitude rule:
  - mag = sample_i negative ? -sample_i : sample_i, taken as SAMPLE_W-bit unsigned.
  - The most negative input maps exactly: -2048 -> 2048 at W=12. No saturation.
- State machine (registered outputs):
  - IDLE: busy_o=0. If start_i, go to ARM and clear accumulator, peak and count. Otherwise stay in IDLE.
  - ARM: timer_start_o=1 for exactly this one cycle, then go to SETTLE.
  - SETTLE: wait for timer_done_i; on that cycle go to ACQUIRE. sample_valid_i is ignored.
  - ACQUIRE:
    - On each sample_valid_i: sum += mag; peak = max(peak, mag); count += 1.
    - On the cycle that accepts sample NUM_SAMPLES, go to REPORT.
  - REPORT:
    - Register sum_o, mean_o and peak_o, including the final sample.
    - result_valid_o=1 for this one cycle, then go to IDLE.
- Latency: result_valid_o asserts exactly 1 cycle after the accepting edge of the last sample. Start to timer_start_o is 1 cycle.
- start_i while busy_o=1 is ignored, with no queuing.
- timer_done_i outside SETTLE is ignored.
- Samples arriving in the REPORT cycle are dropped.
- The accumulator cannot overflow by construction of the sum_o width.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all outputs 0.
  - timer_start_o drops the same instant.
  - A pending timer done after reset is ignored.
- Back-to-back: start_i high in the cycle after REPORT begins a new measurement. Result outputs hold their old values until the next REPORT.

Optional Feature:
- Macro MEAS_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACQUIRE and clears on each accepted sample and on entry to ACQUIRE.
  - When it reaches TIMEOUT_CYCLES, error_o pulses for one cycle and the block returns to IDLE.
  - result_valid_o is not asserted, and sum_o, mean_o and peak_o keep their previous values.
  - SETTLE has no timeout.
- Undefined: no counter; error_o constant 0; ACQUIRE waits indefinitely.

Test Plan:
All tests use NUM_SAMPLES=4, SAMPLE_W=12 and TIMEOUT_CYCLES=32.
1. Nominal: start_i pulse, timer_done_i 10 cycles after timer_start_o, samples 100, -100, 50, -2048 -> result_valid_o 1 cycle after the 4th sample; sum_o=2298, mean_o=574, peak_o=2048.
2. Settle gating: sample_valid_i held high with sample_i=500 during SETTLE, then 4 samples of 1 -> sum_o=4, peak_o=1.
3. Busy ignore: start_i pulsed during SETTLE and again during ACQUIRE -> exactly one timer_start_o pulse and one result_valid_o; busy_o low the cycle after REPORT.
4. Reset mid-ACQUIRE after 2 samples -> all outputs 0 immediately, state IDLE; a following start runs a clean 4-sample measurement with sum_o equal to those 4 samples only.
5. Timeout (MEAS_TIMEOUT_EN defined): 1 sample, then no samples -> error_o pulse 32 cycles later, no result_valid_o, busy_o=0 next cycle. With the macro undefined, the same stimulus leaves busy_o=1 indefinitely and error_o=0.
